// File: rtl/stock_txn_if.sv
// Requester-side bundle for stock_txn_ctrl: the sale and restock request/ack paths.
// The optional low-stock alarm (STOCK_LOW_ALARM_EN) lives on the controller, not here.
interface stock_txn_if;
    logic       sale_req;
    logic [1:0] sale_slot;
    logic [3:0] sale_qty;
    logic       sale_ack;
    logic       sale_ok;
    logic       rstk_req;
    logic [1:0] rstk_slot;
    logic [3:0] rstk_qty;
    logic       rstk_ack;
    logic       rstk_ok;

    modport master (
        output sale_req, sale_slot, sale_qty, rstk_req, rstk_slot, rstk_qty,
        input  sale_ack, sale_ok, rstk_ack, rstk_ok
    );

    modport slave (
        input  sale_req, sale_slot, sale_qty, rstk_req, rstk_slot, rstk_qty,
        output sale_ack, sale_ok, rstk_ack, rstk_ok
    );
endinterface

// File: rtl/stock_txn_ctrl.sv
// Four-slot stock store with a round-robin read-check-modify-write controller for sale and restock.
// Optional macro STOCK_LOW_ALARM_EN adds the registered low_alarm_o output and the LOW_MARK parameter.
module stock_txn_ctrl #(
    parameter int CAPACITY   = 15,
    parameter int INIT_LEVEL = 0
`ifdef STOCK_LOW_ALARM_EN
    ,
    parameter int LOW_MARK   = 2
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       maint_i,
    stock_txn_if.slave bus,
    output logic [1:0] err_code_o,
    output logic [3:0] rest1_o,
    output logic [3:0] rest2_o,
    output logic [3:0] rest3_o,
    output logic [3:0] rest4_o,
    output logic [3:0] room1_o,
    output logic [3:0] room2_o,
    output logic [3:0] room3_o,
    output logic [3:0] room4_o,
    output logic       busy_o
`ifdef STOCK_LOW_ALARM_EN
    ,
    output logic [3:0] low_alarm_o
`endif
);
    localparam logic [3:0] CAP_L     = 4'(CAPACITY);
    localparam logic [3:0] INIT_L    = 4'(INIT_LEVEL);
    localparam logic       PATH_SALE = 1'b0;
    localparam logic       PATH_RSTK = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_GRANT  = 3'd1,
        S_CHECK  = 3'd2,
        S_COMMIT = 3'd3,
        S_REJECT = 3'd4,
        S_ACK    = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic            win_q, win_d;
    logic            prio_q, prio_d;
    logic [1:0]      slot_q, slot_d;
    logic [3:0]      qty_q, qty_d;
    logic [3:0]      cur_q, cur_d;
    logic [1:0]      chk_q, chk_d;
    logic [3:0][3:0] rest_q, rest_d;
    logic            sale_ack_q, sale_ack_d, sale_ok_q, sale_ok_d;
    logic            rstk_ack_q, rstk_ack_d, rstk_ok_q, rstk_ok_d;
    logic [1:0]      err_code_q, err_code_d;
    logic            busy_q, busy_d;
    logic            sale_elig_s, rstk_elig_s;
    logic [4:0]      sum_s;

    assign sale_elig_s = bus.sale_req & ~maint_i;
    assign rstk_elig_s = bus.rstk_req;
    assign sum_s       = {1'b0, cur_q} + {1'b0, qty_q};

    // Next-state, latch and write-back logic for the transaction FSM
    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        prio_d     = prio_q;
        slot_d     = slot_q;
        qty_d      = qty_q;
        cur_d      = cur_q;
        chk_d      = chk_q;
        rest_d     = rest_q;
        sale_ack_d = 1'b0;
        sale_ok_d  = 1'b0;
        rstk_ack_d = 1'b0;
        rstk_ok_d  = 1'b0;
        err_code_d = err_code_q;
        case (state_q)
            S_IDLE: begin
                if (sale_elig_s && rstk_elig_s) begin
                    win_d   = prio_q;
                    state_d = S_GRANT;
                end else if (sale_elig_s) begin
                    win_d   = PATH_SALE;
                    state_d = S_GRANT;
                end else if (rstk_elig_s) begin
                    win_d   = PATH_RSTK;
                    state_d = S_GRANT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GRANT: begin
                if (win_q == PATH_SALE) begin
                    slot_d = bus.sale_slot;
                    qty_d  = bus.sale_qty;
                end else begin
                    slot_d = bus.rstk_slot;
                    qty_d  = bus.rstk_qty;
                end
                cur_d   = rest_q[slot_d];
                state_d = S_CHECK;
            end
            S_CHECK: begin
                // 5-bit sum keeps the over-capacity test free of wrap-around
                if (qty_q == 4'd0) begin
                    chk_d   = 2'd1;
                    state_d = S_REJECT;
                end else if ((win_q == PATH_SALE) && (qty_q > cur_q)) begin
                    chk_d   = 2'd2;
                    state_d = S_REJECT;
                end else if ((win_q == PATH_RSTK) && (sum_s > {1'b0, CAP_L})) begin
                    chk_d   = 2'd3;
                    state_d = S_REJECT;
                end else begin
                    chk_d   = 2'd0;
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                if (win_q == PATH_SALE) begin
                    rest_d[slot_q] = cur_q - qty_q;
                end else begin
                    rest_d[slot_q] = sum_s[3:0];
                end
                sale_ack_d = (win_q == PATH_SALE);
                sale_ok_d  = (win_q == PATH_SALE);
                rstk_ack_d = (win_q == PATH_RSTK);
                rstk_ok_d  = (win_q == PATH_RSTK);
                err_code_d = chk_q;
                state_d    = S_ACK;
            end
            S_REJECT: begin
                sale_ack_d = (win_q == PATH_SALE);
                rstk_ack_d = (win_q == PATH_RSTK);
                err_code_d = chk_q;
                state_d    = S_ACK;
            end
            S_ACK: begin
                prio_d  = ~win_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and datapath registers; reset abandons any transaction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            win_q      <= PATH_SALE;
            prio_q     <= PATH_SALE;
            slot_q     <= 2'd0;
            qty_q      <= 4'd0;
            cur_q      <= 4'd0;
            chk_q      <= 2'd0;
            rest_q     <= {4{INIT_L}};
            sale_ack_q <= 1'b0;
            sale_ok_q  <= 1'b0;
            rstk_ack_q <= 1'b0;
            rstk_ok_q  <= 1'b0;
            err_code_q <= 2'd0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            prio_q     <= prio_d;
            slot_q     <= slot_d;
            qty_q      <= qty_d;
            cur_q      <= cur_d;
            chk_q      <= chk_d;
            rest_q     <= rest_d;
            sale_ack_q <= sale_ack_d;
            sale_ok_q  <= sale_ok_d;
            rstk_ack_q <= rstk_ack_d;
            rstk_ok_q  <= rstk_ok_d;
            err_code_q <= err_code_d;
            busy_q     <= busy_d;
        end
    end

`ifdef STOCK_LOW_ALARM_EN
    localparam logic [3:0] LOW_L = 4'(LOW_MARK);

    function automatic logic [3:0] low_vec(input logic [3:0][3:0] r);
        logic [3:0] v;
        v = 4'd0;
        for (int i = 0; i < 4; i++) begin
            v[i] = (r[i] <= LOW_L);
        end
        return v;
    endfunction

    logic [3:0] low_alarm_q;

    // Alarm tracks the post-commit levels so it moves together with rest
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            low_alarm_q <= low_vec({4{INIT_L}});
        end else begin
            low_alarm_q <= low_vec(rest_d);
        end
    end

    assign low_alarm_o = low_alarm_q;
`endif

    assign bus.sale_ack = sale_ack_q;
    assign bus.sale_ok  = sale_ok_q;
    assign bus.rstk_ack = rstk_ack_q;
    assign bus.rstk_ok  = rstk_ok_q;
    assign err_code_o   = err_code_q;
    assign busy_o       = busy_q;
    assign rest1_o      = rest_q[0];
    assign rest2_o      = rest_q[1];
    assign rest3_o      = rest_q[2];
    assign rest4_o      = rest_q[3];
    assign room1_o      = CAP_L - rest_q[0];
    assign room2_o      = CAP_L - rest_q[1];
    assign room3_o      = CAP_L - rest_q[2];
    assign room4_o      = CAP_L - rest_q[3];
endmodule

// File: tb/tb_stock_txn_ctrl.sv
// Self-checking bench for stock_txn_ctrl: vector table through a scoreboard plus
// contention, maintenance and mid-transaction reset sequences (STOCK_LOW_ALARM_EN adds alarm checks).
module tb_stock_txn_ctrl;
    localparam int CAP = 15;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       maint = 1'b0;
    logic [1:0] err_code;
    logic [3:0] rest1, rest2, rest3, rest4;
    logic [3:0] room1, room2, room3, room4;
    logic       busy;
`ifdef STOCK_LOW_ALARM_EN
    logic [3:0] low_alarm;
`endif

    stock_txn_if bus();

    stock_txn_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .maint_i    (maint),
        .bus        (bus),
        .err_code_o (err_code),
        .rest1_o    (rest1),
        .rest2_o    (rest2),
        .rest3_o    (rest3),
        .rest4_o    (rest4),
        .room1_o    (room1),
        .room2_o    (room2),
        .room3_o    (room3),
        .room4_o    (room4),
        .busy_o     (busy)
`ifdef STOCK_LOW_ALARM_EN
        ,
        .low_alarm_o(low_alarm)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic       sale;
        logic [1:0] slot;
        logic [3:0] qty;
        logic       ok;
        logic [1:0] err;
        logic [3:0] rest;
    } vec_t;

    typedef struct {
        logic       sale;
        logic       ok;
        logic [1:0] err;
        logic [1:0] slot;
        logic [3:0] rest;
        int         ack_cyc;
    } exp_t;

    exp_t sb[$];
    int   checks    = 0;
    int   errors    = 0;
    int   acks_seen = 0;

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int rest_of(input logic [1:0] s);
        case (s)
            2'd0:    return int'(rest1);
            2'd1:    return int'(rest2);
            2'd2:    return int'(rest3);
            default: return int'(rest4);
        endcase
    endfunction

    function automatic int room_of(input logic [1:0] s);
        case (s)
            2'd0:    return int'(room1);
            2'd1:    return int'(room2);
            2'd2:    return int'(room3);
            default: return int'(room4);
        endcase
    endfunction

    // One negedge step; any ack pulse is matched against the scoreboard head
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (bus.sale_ack || bus.rstk_ack) begin
            acks_seen++;
            cmp("dual_ack", int'(bus.sale_ack && bus.rstk_ack), 0);
            if (sb.size() == 0) begin
                cmp("unexpected_ack", 1, 0);
            end else begin
                e = sb.pop_front();
                cmp("ack_path_sale", int'(bus.sale_ack), int'(e.sale));
                cmp("ack_ok", int'(e.sale ? bus.sale_ok : bus.rstk_ok), int'(e.ok));
                cmp("err_code", int'(err_code), int'(e.err));
                cmp("rest_slot", rest_of(e.slot), int'(e.rest));
                cmp("room_slot", room_of(e.slot), CAP - int'(e.rest));
                cmp("ack_cycle", cyc, e.ack_cyc);
            end
        end
    endtask

    task automatic wait_acks(input int n, input int budget);
        int start;
        start = acks_seen;
        for (int i = 0; i < budget && (acks_seen - start) < n; i++) tick();
        if ((acks_seen - start) < n) cmp("ack_timeout", acks_seen - start, n);
    endtask

    task automatic push_exp(input logic sale, input logic ok, input logic [1:0] err,
                            input logic [1:0] slot, input logic [3:0] rest, input int lat);
        exp_t e;
        e.sale = sale; e.ok = ok; e.err = err; e.slot = slot; e.rest = rest;
        e.ack_cyc = cyc + lat;
        sb.push_back(e);
    endtask

    task automatic drive_req(input logic sale, input logic [1:0] slot, input logic [3:0] qty);
        if (sale) begin
            bus.sale_req = 1'b1; bus.sale_slot = slot; bus.sale_qty = qty;
        end else begin
            bus.rstk_req = 1'b1; bus.rstk_slot = slot; bus.rstk_qty = qty;
        end
    endtask

    task automatic run_txn(input vec_t v);
        push_exp(v.sale, v.ok, v.err, v.slot, v.rest, 4);
        drive_req(v.sale, v.slot, v.qty);
        wait_acks(1, 12);
        bus.sale_req = 1'b0;
        bus.rstk_req = 1'b0;
        tick();
    endtask

    vec_t vecs[12];
    vec_t extra;

    initial begin
        vecs[0]  = '{1'b0, 2'd2, 4'd9,  1'b1, 2'd0, 4'd9};
        vecs[1]  = '{1'b1, 2'd2, 4'd10, 1'b0, 2'd2, 4'd9};
        vecs[2]  = '{1'b1, 2'd2, 4'd9,  1'b1, 2'd0, 4'd0};
        vecs[3]  = '{1'b0, 2'd0, 4'd12, 1'b1, 2'd0, 4'd12};
        vecs[4]  = '{1'b0, 2'd0, 4'd4,  1'b0, 2'd3, 4'd12};
        vecs[5]  = '{1'b0, 2'd0, 4'd0,  1'b0, 2'd1, 4'd12};
        vecs[6]  = '{1'b0, 2'd3, 4'd15, 1'b1, 2'd0, 4'd15};
        vecs[7]  = '{1'b0, 2'd3, 4'd1,  1'b0, 2'd3, 4'd15};
        vecs[8]  = '{1'b1, 2'd3, 4'd15, 1'b1, 2'd0, 4'd0};
        vecs[9]  = '{1'b1, 2'd1, 4'd1,  1'b0, 2'd2, 4'd0};
        vecs[10] = '{1'b1, 2'd0, 4'd0,  1'b0, 2'd1, 4'd12};
        vecs[11] = '{1'b0, 2'd1, 4'd7,  1'b1, 2'd0, 4'd7};

        bus.sale_req = 1'b0; bus.sale_slot = 2'd0; bus.sale_qty = 4'd0;
        bus.rstk_req = 1'b0; bus.rstk_slot = 2'd0; bus.rstk_qty = 4'd0;

        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        cmp("reset_busy", int'(busy), 0);
        cmp("reset_err", int'(err_code), 0);
        cmp("reset_acks", int'(bus.sale_ack | bus.rstk_ack), 0);
        for (int s = 0; s < 4; s++) begin
            cmp("reset_rest", rest_of(2'(s)), 0);
            cmp("reset_room", room_of(2'(s)), CAP);
        end
`ifdef STOCK_LOW_ALARM_EN
        cmp("reset_low_alarm", int'(low_alarm), 15);
`endif

        for (int i = 0; i < 12; i++) run_txn(vecs[i]);
        cmp("untouched_rest1", int'(rest1), 12);
        cmp("untouched_rest2", int'(rest2), 7);
        cmp("untouched_rest3", int'(rest3), 0);
        cmp("untouched_rest4", int'(rest4), 0);

        // Both paths held for three grants: sale, restock, sale
        push_exp(1'b1, 1'b1, 2'd0, 2'd0, 4'd10, 4);
        push_exp(1'b0, 1'b1, 2'd0, 2'd1, 4'd10, 9);
        push_exp(1'b1, 1'b1, 2'd0, 2'd0, 4'd8, 14);
        drive_req(1'b1, 2'd0, 4'd2);
        drive_req(1'b0, 2'd1, 4'd3);
        wait_acks(3, 25);
        bus.sale_req = 1'b0;
        bus.rstk_req = 1'b0;
        tick();

        // Maintenance blocks the sale; it is served once maint drops
        maint = 1'b1;
        push_exp(1'b0, 1'b1, 2'd0, 2'd2, 4'd4, 4);
        drive_req(1'b1, 2'd0, 4'd1);
        drive_req(1'b0, 2'd2, 4'd4);
        wait_acks(1, 12);
        bus.rstk_req = 1'b0;
        repeat (6) tick();
        cmp("maint_idle_busy", int'(busy), 0);
        cmp("maint_sale_pending", int'(rest1), 8);
        maint = 1'b0;
        push_exp(1'b1, 1'b1, 2'd0, 2'd0, 4'd7, 4);
        wait_acks(1, 8);
        bus.sale_req = 1'b0;
        tick();

        // Reset during CHECK of a restock aborts it silently
        drive_req(1'b0, 2'd3, 4'd5);
        tick();
        cmp("busy_in_grant", int'(busy), 1);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.rstk_req = 1'b0;
        repeat (6) tick();
        cmp("abort_busy", int'(busy), 0);
        cmp("abort_err", int'(err_code), 0);
        for (int s = 0; s < 4; s++) cmp("abort_rest", rest_of(2'(s)), 0);
        cmp("scoreboard_drained", sb.size(), 0);

`ifdef STOCK_LOW_ALARM_EN
        cmp("post_reset_low_alarm", int'(low_alarm), 15);
        extra = '{1'b0, 2'd1, 4'd5, 1'b1, 2'd0, 4'd5};
        run_txn(extra);
        cmp("low_alarm_bit1_clear", int'(low_alarm), 13);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/stock_txn_ctrl.md
Name: stock_txn_ctrl

Overview:
- Transaction controller for the four-slot stock store that feeds the seven-segment display path.
- Arbitrates between two requesters, the sale path (keypad purchase) and the restock path (keypad restock), both of which modify the same slot quantities.
- Serialises each request as a read-check-modify-write, then reports success or failure.
- Exports remaining quantity and free room per slot.

Parameters:
- CAPACITY, 15, maximum quantity per slot; must be ≤ 15.
- INIT_LEVEL, 0, quantity loaded into every slot at reset; must be ≤ CAPACITY.
- LOW_MARK, 2, low-stock threshold, used only with the optional feature.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- maint  in  1  maintenance mode; while high, sale requests are not granted.
- sale_req  in  1  sale request; held high until sale_ack.
- sale_slot  in  2  slot index 0..3 for the sale.
- sale_qty  in  4  quantity to remove.
- sale_ack  out  1  one-cycle completion pulse for the sale path.
- sale_ok  out  1  sale result, valid with sale_ack; 1 = committed.
- rstk_req  in  1  restock request; held high until rstk_ack.
- rstk_slot  in  2  slot index 0..3 for the restock.
- rstk_qty  in  4  quantity to add.
- rstk_ack  out  1  one-cycle completion pulse for the restock path.
- rstk_ok  out  1  restock result, valid with rstk_ack.
- err_code  out  2  reason for the last completion: 0 ok, 1 zero qty, 2 insufficient stock, 3 over capacity; holds until the next completion.
- rest1..rest4  out  4 each  current quantity of slots 0..3.
- room1..room4  out  4 each  CAPACITY − restN, combinational from registers.
- busy  out  1  high whenever the FSM is not IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE.
  - All rest registers = INIT_LEVEL.
  - Acks, ok flags, busy and err_code = 0.
  - Round-robin pointer points to sale.
- Reset mid-transaction aborts it: no ack is issued and no write occurs.
- FSM states: IDLE → GRANT → CHECK → COMMIT or REJECT → ACK → IDLE.
  - IDLE: a request is eligible if its req is high. sale_req is eligible only when maint=0.
    - One eligible request: that one wins.
    - Both eligible: the path not served last wins.
    - Winner found: go to GRANT.
  - GRANT: latch the winner's id, slot, qty and the current rest[slot]. Inputs are not sampled again afterwards. If maint rises after grant, a granted sale still completes.
  - CHECK, using a 5-bit sum/difference:
    - qty = 0 → err 1, REJECT.
    - Sale with qty > rest → err 2, REJECT.
    - Restock with rest + qty > CAPACITY → err 3, REJECT.
    - Otherwise → err 0, COMMIT.
  - COMMIT: rest[slot] ← rest − qty (sale) or rest + qty (restock). Exactly one slot is written; the other slots are untouched.
  - REJECT: no register write.
  - ACK: the winner's ack = 1 for exactly this cycle. The ok flag = 1 if the transaction was COMMIT, else 0. err_code is updated here. Update the round-robin pointer to the other path.
- Latency: req sampled in IDLE at cycle 0 → ack high in cycle 4, with a 1-cycle REJECT/COMMIT slot. Next grant is possible from cycle 5.
- Throughput: one transaction per 5 cycles.
- Handshake: the requester drops req on the edge after it sees ack. req still high in IDLE after ack is treated as a new request.
- A loser's request stays pending and is served next; no starvation.
- rest never exceeds CAPACITY and never wraps below 0.
- sale_ack and rstk_ack are never high together.

Optional Feature:
- Macro: STOCK_LOW_ALARM_EN.
- When defined:
  - Adds output low_alarm [3:0]. Bit i is registered high when rest(i+1) ≤ LOW_MARK and low otherwise.
  - Updated in the cycle after any COMMIT or reset. Reset value is computed from INIT_LEVEL, so it is 4'hF for default parameters.
  - Additionally, a sale that commits and leaves rest = 0 sets err_code to 0 (unchanged semantics) and pulses low_alarm bit high with the rest.
- When not defined: no low_alarm port, no LOW_MARK logic; all other behaviour is identical.

Test Plan:
- Reset with INIT_LEVEL=0; restock slot 2 qty 9 → rstk_ack at cycle 4, rstk_ok=1, rest3=9, room3=6, err_code=0.
- Slot 2 = 9: sale slot 2 qty 10 → sale_ok=0, err_code=2, rest3 stays 9. Then sale qty 9 → ok=1, rest3=0.
- Restock slot 0 qty 12, then qty 4 → second restock rejected with err_code=3, rest1=12. Restock qty 0 → err_code=1.
- sale_req and rstk_req asserted in the same cycle, both held for 3 transactions: grant order sale, restock, sale; never two acks in the same cycle.
- maint=1 with sale_req and rstk_req both high → only restock served; sale pending. maint=0 → sale served within 5 cycles.
- rst_n pulsed low during CHECK of a restock qty 5 → no ack, all rest = INIT_LEVEL, busy=0. With STOCK_LOW_ALARM_EN: low_alarm=4'hF after reset; restock slot 1 qty 5 → bit 1 clears.
